srl_chain_reader: RTL and testbench

Behavioural 4×32-stage addressable shift chain with a snapshot readback engine, used as the read-out counterpart to the SRLC32E chain minitests. Serial data shifts in on a clock enable. On request, the block freezes the chain, sweeps all 32 tap addresses across the four segments, and streams the 128-bit contents out as four 32-bit words over a valid/ready handshake. It gives the SRL fuzzers and benches a cycle-exact golden model and a dump path for comparison against fabric results.

---
 rtl/srl_chain_reader.sv | 156 +++++++++++++++
 tb/tb_srl_chain_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/srl_chain_reader.sv
// 4x32 addressable shift chain with a snapshot readback engine that streams the
// frozen 128-bit contents as four 32-bit words. Optional parity: SRL_READER_PARITY_EN.
module srl_chain_reader (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic        D,
    input  logic [4:0]  A,
    output logic        Q,
    output logic        Q31,
    input  logic        START,
    output logic        BUSY,
    output logic [31:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_PAR,
    output logic        DONE,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t       state, state_nx;
    logic [127:0] chain;
    logic [4:0]   addr, addr_nx;
    logic [1:0]   word, word_nx;
    logic [31:0]  acc, acc_nx;
    logic [31:0]  acc_ins;
    logic [31:0]  out_data_nx;
    logic         out_valid_nx;
    logic         busy_nx;
    logic         done_nx;
    logic [3:0]   tap_nibble;
    logic         last_capture;

    // Chain is frozen while BUSY; the edge that accepts START still shifts.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            chain <= '0;
        end else if (CE && !BUSY) begin
            chain <= {chain[126:0], D};
        end
    end

    assign Q   = chain[{2'b11, A}];
    assign Q31 = chain[127];

    assign tap_nibble = {chain[{2'b11, addr}], chain[{2'b10, addr}],
                         chain[{2'b01, addr}], chain[{2'b00, addr}]};
    assign last_capture = (addr[2:0] == 3'd7);

    always_comb begin
        acc_ins = acc;
        acc_ins[{addr[2:0], 2'b00} +: 4] = tap_nibble;
    end

    // Handshake: a word transfers on a rising edge where OUT_VALID && OUT_READY;
    // OUT_DATA/OUT_PAR are held stable while OUT_VALID is high and not accepted,
    // and OUT_VALID drops on the accepting edge (no back-to-back words).
    always_comb begin
        state_nx     = state;
        addr_nx      = addr;
        word_nx      = word;
        acc_nx       = acc;
        out_data_nx  = OUT_DATA;
        out_valid_nx = OUT_VALID;
        busy_nx      = BUSY;
        done_nx      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nx = ST_SWEEP;
                    addr_nx  = 5'd0;
                    word_nx  = 2'd0;
                    acc_nx   = '0;
                    busy_nx  = 1'b1;
                end
            end
            ST_SWEEP: begin
                acc_nx  = acc_ins;
                addr_nx = addr + 5'd1;
                if (last_capture) begin
                    out_data_nx  = acc_ins;
                    out_valid_nx = 1'b1;
                    state_nx     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (OUT_READY) begin
                    out_valid_nx = 1'b0;
                    if (word != 2'd3) begin
                        word_nx  = word + 2'd1;
                        state_nx = ST_SWEEP;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            addr      <= '0;
            word      <= '0;
            acc       <= '0;
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            word      <= word_nx;
            acc       <= acc_nx;
            OUT_DATA  <= out_data_nx;
            OUT_VALID <= out_valid_nx;
            BUSY      <= busy_nx;
            DONE      <= done_nx;
        end
    end

    assign dbg_state = state;

`ifdef SRL_READER_PARITY_EN
    logic par_q;

    // Loaded on the same edge as OUT_DATA so it is valid with OUT_VALID.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_q <= 1'b0;
        end else if (state == ST_SWEEP && last_capture) begin
            par_q <= ^acc_ins;
        end
    end

    assign OUT_PAR = par_q;
`else
    assign OUT_PAR = 1'b0;
`endif

endmodule

// File: tb/tb_srl_chain_reader.sv
// Directed bench for srl_chain_reader: reset, live taps, full dumps,
// backpressure, reset mid-readback and parity.
module tb_srl_chain_reader;

`ifdef SRL_READER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        d = 1'b0;
    logic [4:0]  a = 5'd0;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        q, q31, busy, out_valid, out_par, done;
    logic [31:0] out_data;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    logic [31:0] rb_w[4];
    logic        rb_p[4];
    int          rb_nwords, rb_done_k, rb_done_cnt;
    bit          rb_stall_ok, rb_timeout;

    srl_chain_reader dut (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .D(d), .A(a), .Q(q), .Q31(q31),
        .START(start), .BUSY(busy), .OUT_DATA(out_data), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_PAR(out_par), .DONE(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1);
    end

    function automatic logic exp_par(input logic [31:0] v);
        return PAR_EN ? ^v : 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0; ce = 1'b0; start = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic shift_bits(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ce = 1'b1; d = b;
        end
        @(negedge clk);
        ce = 1'b0;
    endtask

    // Runs one readback; optional stall on word 0 toggles CE/START meanwhile.
    task automatic readback(input int stall, input bit ce_at_start);
        int k;
        bit stalled;
        logic [31:0] snap;
        k = 0; stalled = 0; rb_nwords = 0; rb_done_k = -1; rb_done_cnt = 0;
        rb_stall_ok = 1; rb_timeout = 0;
        for (int i = 0; i < 4; i++) begin
            rb_w[i] = 32'hdead_beef; rb_p[i] = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; ce = ce_at_start; d = 1'b0;
        @(negedge clk);
        start = 1'b0; ce = 1'b0;
        while (1) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) begin
                rb_done_cnt++;
                if (rb_done_k < 0) rb_done_k = k;
            end
            if (out_valid === 1'b1 && stall > 0 && !stalled) begin
                stalled = 1; out_ready = 1'b0; snap = out_data;
                repeat (stall) begin
                    @(negedge clk);
                    k++;
                    ce = ~ce; start = ~start;
                    if (out_data !== snap || out_valid !== 1'b1 || busy !== 1'b1)
                        rb_stall_ok = 0;
                end
                ce = 1'b0; start = 1'b0; out_ready = 1'b1;
            end
            if (out_valid === 1'b1 && out_ready && rb_nwords < 4) begin
                rb_w[rb_nwords] = out_data;
                rb_p[rb_nwords] = out_par;
                rb_nwords++;
            end
            if (busy !== 1'b1) break;
            if (k >= 400) begin
                rb_timeout = 1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL rst_data got %h exp 00000000", out_data); else n_pass++;
        n_checks++; if (out_par !== 1'b0) $display("FAIL rst_par got %b exp 0", out_par); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
        n_checks++; if (q31 !== 1'b0) $display("FAIL rst_q31 got %b exp 0", q31); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL rst_state got %0d exp 0", dbg_state); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_live_tap();
        shift_bits(1'b1, 1);
        shift_bits(1'b0, 101);
        a = 5'd5; #1;
        n_checks++; if (q !== 1'b1) $display("FAIL tap_a5 got %b exp 1", q); else n_pass++;
        n_checks++; if (q31 !== 1'b0) $display("FAIL tap_q31 got %b exp 0", q31); else n_pass++;
        a = 5'd4; #1;
        n_checks++; if (q !== 1'b0) $display("FAIL tap_a4 got %b exp 0", q); else n_pass++;
    endtask

    task automatic test_full_dump();
        logic [31:0] e;
        do_reset();
        shift_bits(1'b1, 1);
        shift_bits(1'b0, 127);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h8000_0000);
        readback(0, 1'b0);
        n_checks++; if (rb_timeout !== 1'b0) $display("FAIL dump_timeout got %b exp 0", rb_timeout); else n_pass++;
        n_checks++; if (rb_nwords !== 4) $display("FAIL dump_nwords got %0d exp 4", rb_nwords); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_checks++; if (rb_w[i] !== e) $display("FAIL dump_word%0d got %h exp %h", i, rb_w[i], e); else n_pass++;
            n_checks++; if (rb_p[i] !== exp_par(e)) $display("FAIL dump_par%0d got %b exp %b", i, rb_p[i], exp_par(e)); else n_pass++;
        end
        n_checks++; if (rb_done_k !== 36) $display("FAIL dump_done_lat got %0d exp 36", rb_done_k); else n_pass++;
        n_checks++; if (rb_done_cnt !== 1) $display("FAIL dump_done_width got %0d exp 1", rb_done_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] first[4];
        logic [31:0] e;
        d = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h8000_0000);
        readback(5, 1'b0);
        n_checks++; if (rb_stall_ok !== 1'b1) $display("FAIL bp_stable got %b exp 1", rb_stall_ok); else n_pass++;
        n_checks++; if (rb_nwords !== 4) $display("FAIL bp_nwords got %0d exp 4", rb_nwords); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            first[i] = rb_w[i];
            n_checks++; if (rb_w[i] !== e) $display("FAIL bp_word%0d got %h exp %h", i, rb_w[i], e); else n_pass++;
        end
        n_checks++; if (rb_done_k !== 41) $display("FAIL bp_done_lat got %0d exp 41", rb_done_k); else n_pass++;
        n_checks++; if (q31 !== 1'b1) $display("FAIL bp_q31 got %b exp 1", q31); else n_pass++;
        readback(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rb_w[i] !== first[i]) $display("FAIL bp_repeat%0d got %h exp %h", i, rb_w[i], first[i]); else n_pass++;
        end
    endtask

    task automatic test_shift_at_start();
        do_reset();
        shift_bits(1'b1, 1);
        shift_bits(1'b0, 126);
        readback(0, 1'b1);
        n_checks++; if (rb_w[3] !== 32'h8000_0000) $display("FAIL start_shift_w3 got %h exp 80000000", rb_w[3]); else n_pass++;
        n_checks++; if (q31 !== 1'b1) $display("FAIL start_shift_q31 got %b exp 1", q31); else n_pass++;
    endtask

    task automatic test_reset_in_hold();
        int k;
        do_reset();
        shift_bits(1'b1, 128);
        @(negedge clk);
        start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (out_data !== 32'hffff_ffff) $display("FAIL hold_word0 got %h exp ffffffff", out_data); else n_pass++;
        #2 rst_n = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL hold_rst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL hold_rst_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL hold_rst_data got %h exp 00000000", out_data); else n_pass++;
        n_checks++; if (q31 !== 1'b0) $display("FAIL hold_rst_q31 got %b exp 0", q31); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL hold_rst_state got %0d exp 0", dbg_state); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        readback(0, 1'b0);
        n_checks++; if (rb_nwords !== 4) $display("FAIL hold_after_nwords got %0d exp 4", rb_nwords); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rb_w[i] !== 32'h0) $display("FAIL hold_after_word%0d got %h exp 00000000", i, rb_w[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        shift_bits(1'b1, 40);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (dbg_state !== 2'd1) $display("FAIL sweep_state got %0d exp 1", dbg_state); else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL sweep_rst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL sweep_rst_valid got %b exp 0", out_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        readback(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rb_w[i] !== 32'h0) $display("FAIL sweep_after_word%0d got %h exp 00000000", i, rb_w[i]); else n_pass++;
        end
    endtask

    task automatic test_parity();
        logic [31:0] e;
        do_reset();
        shift_bits(1'b1, 3);
        shift_bits(1'b0, 29);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1110_0000);
        readback(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_checks++; if (rb_w[i] !== e) $display("FAIL par_a_word%0d got %h exp %h", i, rb_w[i], e); else n_pass++;
            n_checks++; if (rb_p[i] !== exp_par(e)) $display("FAIL par_a_par%0d got %b exp %b", i, rb_p[i], exp_par(e)); else n_pass++;
        end
        shift_bits(1'b0, 96);
        readback(0, 1'b0);
        n_checks++; if (rb_w[3] !== 32'h8880_0000) $display("FAIL par_b_word3 got %h exp 88800000", rb_w[3]); else n_pass++;
        n_checks++; if (rb_p[3] !== exp_par(32'h8880_0000)) $display("FAIL par_b_par3 got %b exp %b", rb_p[3], exp_par(32'h8880_0000)); else n_pass++;
        n_checks++; if (rb_p[0] !== 1'b0) $display("FAIL par_b_par0 got %b exp 0", rb_p[0]); else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_live_tap();
        test_full_dump();
        test_backpressure();
        test_shift_at_start();
        test_reset_in_hold();
        test_reset_mid_sweep();
        test_parity();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
